rr_arbiter8: RTL and testbench

RR_ARBITER8 -- requirements
Module: rr_arbiter8

---
 rtl/rr_arbiter8.sv | 130 +++++++++++++
 tb/tb_rr_arbiter8.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter: one registered grant at a time, each held for a latched
// per-requester time or until the grantee drops its request.

module rr_arbiter8_lane #(
    parameter int IW  = 3,
    parameter int TW  = 4,
    parameter int IDX = 0
) (
    input  logic          req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic [TW-1:0] time_i,
    output logic          hi_o,
    output logic [TW-1:0] tload_o
);
    localparam logic [IW-1:0] IDXV = IW'(IDX);

    // Lanes at or above the pointer win over lanes that wrap around below it.
    assign hi_o    = req_i & (IDXV >= ptr_i);
    assign tload_o = (time_i == '0) ? TW'(1) : time_i;
endmodule

module rr_arbiter8 #(
    parameter int N  = 8,
    parameter int TW = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [N-1:0]         REQ,
    input  logic [N*TW-1:0]      REQ_TIME,
    output logic [N-1:0]         GNT,
    output logic [$clog2(N)-1:0] GNT_ID,
    output logic                 BUSY,
    output logic                 DONE
);
    localparam int IW = $clog2(N);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       id_q, id_d;
    logic [TW-1:0]       cnt_q, cnt_d;
    logic [N-1:0]        gnt_q, gnt_d;
    logic                done_q, done_d;

    logic [N-1:0]         hi;
    logic [N-1:0][TW-1:0] tload;
    logic [IW-1:0]        sel_id;

    for (genvar g = 0; g < N; g++) begin : g_lane
        rr_arbiter8_lane #(.IW(IW), .TW(TW), .IDX(g)) u_lane (
            .req_i   (REQ[g]),
            .ptr_i   (ptr_q),
            .time_i  (REQ_TIME[g*TW +: TW]),
            .hi_o    (hi[g]),
            .tload_o (tload[g])
        );
    end

    // Lowest set bit of the upper window if any, else lowest set request overall.
    always_comb begin
        sel_id = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (REQ[i]) sel_id = IW'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (hi[i]) sel_id = IW'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|REQ) begin
                    state_d = S_HOLD;
                    id_d    = sel_id;
                    gnt_d   = N'(1) << sel_id;
                    cnt_d   = tload[sel_id];
                end
            end
            S_HOLD: begin
                if (!REQ[id_q] || cnt_q <= TW'(1)) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    id_d    = '0;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    ptr_d   = (id_q == IW'(N - 1)) ? '0 : id_q + IW'(1);
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                id_d    = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    assign GNT    = gnt_q;
    assign GNT_ID = id_q;
    assign BUSY   = |gnt_q;
    assign DONE   = done_q;
endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed vector table, reset-in-grant sequence and a
// randomized multi-requester run against a cycle model through a scoreboard.

module tb_rr_arbiter8;
    logic        CLK;
    logic        RESET;
    logic [7:0]  req;
    logic [31:0] tm;
    logic [7:0]  gnt;
    logic [2:0]  gnt_id;
    logic        busy;
    logic        done;

    rr_arbiter8 #(.N(8), .TW(4)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(req), .REQ_TIME(tm),
        .GNT(gnt), .GNT_ID(gnt_id), .BUSY(busy), .DONE(done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] id;
        logic       busy;
        logic       done;
    } exp_t;

    typedef struct {
        bit          rst;
        logic [7:0]  req;
        logic [31:0] tm;
        logic [7:0]  gnt;
        logic [2:0]  id;
        logic        done;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    bit   chk_en = 0;
    exp_t sbq[$];
    vec_t vtab[$];

    // Reference model state
    bit         m_hold;
    int         m_ptr, m_id, m_cnt;
    logic [7:0] m_gnt;
    logic       m_done;

    function automatic exp_t mk(logic [7:0] g, int id, logic d);
        exp_t e;
        e.gnt = g; e.id = 3'(id); e.busy = |g; e.done = d;
        return e;
    endfunction

    task automatic add(bit r, logic [7:0] rq, logic [31:0] t, logic [7:0] g, int id, logic d);
        vec_t v;
        v.rst = r; v.req = rq; v.tm = t; v.gnt = g; v.id = 3'(id); v.done = d;
        vtab.push_back(v);
    endtask

    task automatic m_reset();
        m_hold = 0; m_ptr = 0; m_id = 0; m_cnt = 0; m_gnt = '0; m_done = 0;
    endtask

    task automatic model_step();
        if (RESET) begin
            m_reset();
            return;
        end
        m_done = 0;
        if (m_hold) begin
            if (!req[m_id] || m_cnt == 1) begin
                m_hold = 0; m_gnt = '0; m_done = 1;
                m_ptr = (m_id + 1) % 8; m_id = 0;
            end else begin
                m_cnt--;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                int j;
                j = (m_ptr + k) % 8;
                if (req[j]) begin
                    m_hold = 1; m_id = j; m_gnt = 8'(1) << j;
                    m_cnt = int'(tm[j*4 +: 4]);
                    if (m_cnt == 0) m_cnt = 1;
                    break;
                end
            end
        end
    endtask

    task automatic check_out(exp_t e, string nm);
        n_vec++;
        if (gnt !== e.gnt || gnt_id !== e.id || busy !== e.busy || done !== e.done) begin
            n_err++;
            $display("FAIL %s: got gnt=%h id=%0d busy=%b done=%b, want gnt=%h id=%0d busy=%b done=%b",
                     nm, gnt, gnt_id, busy, done, e.gnt, e.id, e.busy, e.done);
        end
    endtask

    // One clock: model steps on the edge, expectation queued, compared at negedge.
    task automatic tick(exp_t e_tab, bit use_tab, string nm);
        exp_t e;
        @(posedge CLK);
        model_step();
        sbq.push_back(use_tab ? e_tab : mk(m_gnt, m_id, m_done));
        @(negedge CLK);
        e = sbq.pop_front();
        check_out(e, nm);
    endtask

    task automatic do_reset(string nm);
        RESET = 1'b1;
        #1;
        check_out(mk(8'h00, 0, 1'b0), {nm, "_async"});
        m_reset();
        @(negedge CLK);
        check_out(mk(8'h00, 0, 1'b0), {nm, "_held"});
        RESET = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            n_vec++;
            if (!$onehot0(gnt) || busy !== (|gnt)) begin
                n_err++;
                $display("FAIL onehot_busy: gnt=%h busy=%b, want onehot0 gnt and busy=%b", gnt, busy, |gnt);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

    initial begin
        int  seqs[8];
        bit  on[8];
        bit  seen[8];
        bit  all_done;
        int  cyc;

        RESET = 1'b0; req = '0; tm = '0;
        m_reset();

        // Single request with hold time 3; REQ_TIME changes after grant are ignored.
        add(1, 8'h04, 32'h0000_0300, 8'h04, 2, 0);
        add(0, 8'h04, 32'h0000_0F00, 8'h04, 2, 0);
        add(0, 8'h04, 32'h0000_0000, 8'h04, 2, 0);
        add(0, 8'h04, 32'h0000_0300, 8'h00, 0, 1);
        add(0, 8'h09, 32'h0000_1001, 8'h08, 3, 0);
        add(0, 8'h09, 32'h0000_1001, 8'h00, 0, 1);
        add(0, 8'h01, 32'h0000_1001, 8'h01, 0, 0);
        add(0, 8'h00, 32'h0000_1001, 8'h00, 0, 1);
        add(0, 8'h00, 32'h0000_1001, 8'h00, 0, 0);
        // All eight requesting with time 1.
        for (int k = 0; k < 8; k++) begin
            add(k == 0, 8'hFF, 32'h1111_1111, 8'(1) << k, k, 0);
            add(0, 8'hFF, 32'h1111_1111, 8'h00, 0, 1);
        end
        add(0, 8'hFF, 32'h1111_1111, 8'h01, 0, 0);
        // Zero hold time behaves as one.
        add(1, 8'h20, 32'h0000_0000, 8'h20, 5, 0);
        add(0, 8'h20, 32'h0000_0000, 8'h00, 0, 1);
        add(0, 8'h00, 32'h0000_0000, 8'h00, 0, 0);
        // Early release after four grant cycles of a nine-cycle hold.
        add(1, 8'h02, 32'h0000_0090, 8'h02, 1, 0);
        for (int k = 0; k < 3; k++) add(0, 8'h02, 32'h0000_0090, 8'h02, 1, 0);
        add(0, 8'h00, 32'h0000_0090, 8'h00, 0, 1);
        add(0, 8'h00, 32'h0000_0090, 8'h00, 0, 0);
        // Pointer at 6 with REQ=41: 6, 0, 6.
        add(1, 8'h20, 32'h1111_1111, 8'h20, 5, 0);
        add(0, 8'h41, 32'h1111_1111, 8'h00, 0, 1);
        add(0, 8'h41, 32'h1111_1111, 8'h40, 6, 0);
        add(0, 8'h41, 32'h1111_1111, 8'h00, 0, 1);
        add(0, 8'h41, 32'h1111_1111, 8'h01, 0, 0);
        add(0, 8'h41, 32'h1111_1111, 8'h00, 0, 1);
        add(0, 8'h41, 32'h1111_1111, 8'h40, 6, 0);
        add(0, 8'h41, 32'h1111_1111, 8'h00, 0, 1);

        @(negedge CLK);
        do_reset("init");
        chk_en = 1;

        foreach (vtab[i]) begin
            if (vtab[i].rst) do_reset($sformatf("vrst%0d", i));
            req = vtab[i].req;
            tm  = vtab[i].tm;
            tick(mk(vtab[i].gnt, int'(vtab[i].id), vtab[i].done), 1, $sformatf("vec%0d", i));
        end

        // Reset during the second cycle of a six-cycle grant to requester 7.
        do_reset("pre7");
        req = 8'h80; tm = 32'h6000_0000;
        tick(mk(8'h80, 7, 0), 1, "g7_c1");
        tick(mk(8'h80, 7, 0), 1, "g7_c2");
        RESET = 1'b1;
        #1;
        check_out(mk(8'h00, 0, 0), "g7_async_drop");
        m_reset();
        tick(mk(8'h00, 0, 0), 1, "g7_no_done");
        RESET = 1'b0;
        req = 8'h81; tm = 32'h1000_0001;
        tick(mk(8'h01, 0, 0), 1, "post_rst_g0");
        tick(mk(8'h00, 0, 1), 1, "post_rst_rel");
        tick(mk(8'h80, 7, 0), 1, "post_rst_g7");
        tick(mk(8'h00, 0, 1), 1, "post_rst_rel7");

        // Randomized: each requester runs 200 request sequences concurrently.
        req = '0;
        foreach (seqs[i]) begin seqs[i] = 0; on[i] = 0; seen[i] = 0; end
        cyc = 0;
        all_done = 0;
        while (!all_done && cyc < 60000) begin
            if ($urandom_range(599) == 0) begin
                do_reset("rand_rst");
                foreach (seen[i]) seen[i] = 0;
            end
            for (int i = 0; i < 8; i++) begin
                if (on[i]) begin
                    if (seen[i] && !m_gnt[i]) begin
                        on[i] = 0; seqs[i]++;
                    end else if (m_gnt[i]) begin
                        seen[i] = 1;
                        if ($urandom_range(7) == 0) begin
                            on[i] = 0; seqs[i]++;
                        end else if ($urandom_range(3) == 0) begin
                            tm[i*4 +: 4] = 4'($urandom_range(15));
                        end
                    end
                end else if (seqs[i] < 200 && $urandom_range(2) == 0) begin
                    on[i] = 1; seen[i] = 0;
                    tm[i*4 +: 4] = 4'($urandom_range(7));
                end
                req[i] = on[i];
            end
            tick(mk(8'h00, 0, 0), 0, "rand");
            cyc++;
            all_done = 1;
            foreach (seqs[i]) if (seqs[i] < 200) all_done = 0;
        end
        n_vec++;
        if (!all_done) begin
            n_err++;
            $display("FAIL rand_budget: got incomplete after %0d cycles, want 200 sequences per requester", cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
